frame_buffer_writer: RTL

Write-side controller for the 3-row circular `frame_buffer`, sitting directly upstream of it. It accepts a raster-ordered pixel stream over a valid/ready handshake and generates `frame_buffer` column, row, pixel and write-enable signals. It tracks how many complete, unconsumed rows the buffer holds, and stalls the stream when all rows are full. It tells the downstream window/filter stage when a full row window is available.

---
 rtl/frame_buffer_writer.sv | 72 +++++++
 1 files changed

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: turns a raster pixel stream into circular frame_buffer writes and tracks filled rows
module frame_buffer_writer #(
  parameter int P_COLUMNS = 640,
  parameter int P_ROWS = 3,
  parameter int P_PIXEL_DEPTH = 24
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
  input  logic                           I_PIXEL_VALID,
  input  logic                           I_FRAME_START,
  output logic                           O_PIXEL_READY,
  input  logic                           I_ROW_CONSUMED,
  output logic [$clog2(P_COLUMNS)-1:0]   O_PIXEL_COL,
  output logic [$clog2(P_ROWS)-1:0]      O_PIXEL_ROW,
  output logic [P_PIXEL_DEPTH-1:0]       O_PIXEL,
  output logic                           O_WRITE_ENABLE,
  output logic                           O_ROW_DONE,
  output logic [$clog2(P_ROWS)-1:0]      O_ROW_INDEX,
  output logic [$clog2(P_ROWS+1)-1:0]    O_ROWS_FILLED,
  output logic                           O_WINDOW_VALID
);
  localparam int CW = $clog2(P_COLUMNS);
  localparam int RW = $clog2(P_ROWS);
  localparam int FW = $clog2(P_ROWS + 1);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;
  state_t r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [FW-1:0] r_fill;
  logic w_accept, w_start, w_norm, w_last, w_consume;
  logic [FW-1:0] w_fill_next;
  assign O_PIXEL_READY = !I_RESET && I_ENABLE && r_state != S_FULL;
  assign w_accept = I_PIXEL_VALID && O_PIXEL_READY;
  assign w_start = w_accept && I_FRAME_START;
  assign w_norm = w_accept && !I_FRAME_START && r_state == S_FILL;
  assign w_last = w_norm && r_col == CW'(P_COLUMNS - 1);
  assign w_consume = I_ENABLE && I_ROW_CONSUMED && r_state != S_IDLE && r_fill != '0;
  assign w_fill_next = w_start ? '0 : r_fill + FW'(w_last) - FW'(w_consume);
  assign O_ROWS_FILLED = r_fill;
  assign O_WINDOW_VALID = r_fill == FW'(P_ROWS);
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state <= S_IDLE;
      r_col <= '0;
      r_row <= '0;
      r_fill <= '0;
      O_PIXEL_COL <= '0;
      O_PIXEL_ROW <= '0;
      O_PIXEL <= '0;
      O_WRITE_ENABLE <= 1'b0;
      O_ROW_DONE <= 1'b0;
      O_ROW_INDEX <= '0;
    end else begin
      O_WRITE_ENABLE <= w_start || w_norm;
      O_ROW_DONE <= w_last;
      if (w_start || w_norm) begin
        O_PIXEL_COL <= w_start ? '0 : r_col;
        O_PIXEL_ROW <= w_start ? '0 : r_row;
        O_PIXEL <= I_PIXEL;
        r_col <= w_start ? CW'(1) : w_last ? '0 : r_col + CW'(1);
        r_row <= w_start ? '0 : !w_last ? r_row : r_row == RW'(P_ROWS - 1) ? '0 : r_row + RW'(1);
      end
      if (w_last) O_ROW_INDEX <= r_row;
      if (w_start || r_state != S_IDLE) begin
        r_fill <= w_fill_next;
        r_state <= w_fill_next == FW'(P_ROWS) ? S_FULL : S_FILL;
      end
    end
  end
endmodule
